// File: rtl/mux_sched_pkg.sv
// Shared types and the rotate-priority pick used by the round-robin scheduler.
package mux_sched_pkg;

    typedef enum logic {IDLE, LOCKED} sched_state_t;

    localparam int unsigned RR_MAX_REQ = 16;
    localparam int unsigned RR_IDX_W   = 4;
    localparam int unsigned RR_POS_W   = RR_IDX_W + 1;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req[n-1:0] scanning ptr, ptr+1, ... modulo n.
    // The wrap is a conditional subtract, so no divider is inferred for odd n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                         input logic [RR_IDX_W-1:0]   ptr,
                                         input int unsigned           n);
        rr_pick_t             res;
        logic [RR_POS_W-1:0]  pos;
        res = '0;
        for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
            pos = {1'b0, ptr} + RR_POS_W'(k);
            if (pos >= RR_POS_W'(n)) begin
                pos = pos - RR_POS_W'(n);
            end
            if ((k < n) && !res.found && req[pos[RR_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = pos[RR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Combinational rotate-priority encoder: index of the first request at or after i_ptr.
module rr_pick_onehot
    import mux_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned SEL_W = 2
)(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_valid
);

    logic [RR_MAX_REQ-1:0] w_req_ext;
    logic [RR_IDX_W-1:0]   w_ptr_ext;
    rr_pick_t              w_pick;
    logic                  w_unused_idx;

    // Widen to the package's fixed width, then scan only the first N_REQ positions.
    always_comb begin
        w_req_ext               = '0;
        w_req_ext[N_REQ-1:0]    = i_req;
        w_ptr_ext               = '0;
        w_ptr_ext[SEL_W-1:0]    = i_ptr;
        w_pick                  = rr_pick(w_req_ext, w_ptr_ext, N_REQ);
    end

    assign o_idx        = w_pick.idx[SEL_W-1:0];
    assign o_valid      = w_pick.found;
    assign w_unused_idx = ^w_pick.idx;

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin packet scheduler in front of an N:1 mux: grants one requester per
// packet (or MAX_BEATS beats), drives the select, forwards valid/ready.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter  int unsigned N_REQ     = 4,
    parameter  int unsigned DATA_W    = 8,
    parameter  int unsigned MAX_BEATS = 16,
    localparam int unsigned SEL_W     = $clog2(N_REQ)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        sel,
    output logic                    busy,
    output logic                    preempt
);

    localparam int unsigned      CNT_W     = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);
    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(N_REQ - 1);

    sched_state_t     r_state, w_state_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic             r_preempt, w_preempt_nxt;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic             w_xfer;

    rr_pick_onehot #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // State, grant index, scan pointer, beat count and preempt pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
            r_preempt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_preempt  <= w_preempt_nxt;
        end
    end

    // Arbitration in IDLE; handshake forwarding and release decision in LOCKED.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_ptr_nxt      = r_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_preempt_nxt  = 1'b0;
        req_ready      = '0;
        out_valid      = 1'b0;
        busy           = 1'b0;
        w_xfer         = 1'b0;
        out_data       = req_data[r_sel*DATA_W +: DATA_W];
        out_last       = req_last[r_sel];
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt    = LOCKED;
                    w_sel_nxt      = w_pick_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                busy             = 1'b1;
                out_valid        = req_valid[r_sel];
                req_ready[r_sel] = out_ready;
                w_xfer           = out_valid && out_ready;
                if (w_xfer) begin
                    if (out_last || (r_beat_cnt == CNT_LIMIT)) begin
                        w_state_nxt    = IDLE;
                        w_ptr_nxt      = (r_sel == SEL_MAX) ? '0 : r_sel + 1'b1;
                        w_beat_cnt_nxt = '0;
                        w_preempt_nxt  = !out_last;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign sel     = r_sel;
    assign preempt = r_preempt;

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
Round-robin scheduler that shares one N:1 multiplexed output channel among N_REQ requesters. It grants one requester at a time and drives the mux select. It holds the grant for a whole packet, from the first beat to the beat marked last. It forwards a valid/ready handshake between the granted requester and the shared output. It sits in front of the existing mux tree, which implements the data path selected by `sel`.

Parameters:
- N_REQ, 4: number of requesters (2..16; need not be a power of two).
- DATA_W, 8: payload width per requester.
- MAX_BEATS, 16: maximum beats per grant before forced release (≥1).
- SEL_W, $clog2(N_REQ): select width (derived; not overridden).

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, N_REQ: per-requester beat valid.
- req_data, in, N_REQ*DATA_W: packed payloads; requester i occupies [i*DATA_W +: DATA_W].
- req_last, in, N_REQ: per-requester last-beat flag.
- req_ready, out, N_REQ: per-requester ready; one-hot or zero.
- out_valid, out, 1: shared channel valid.
- out_data, out, DATA_W: shared channel payload.
- out_last, out, 1: shared channel last flag.
- out_ready, in, 1: downstream ready.
- sel, out, SEL_W: registered mux select; index of the current/last grant.
- busy, out, 1: high while a grant is held.
- preempt, out, 1: one-cycle pulse when MAX_BEATS forces release.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE, sel=0, ptr=0, beat_cnt=0.
  - busy=0, preempt=0, req_ready=0, out_valid=0.
  - out_data and out_last are don't-care while out_valid=0.
- Reset asserted mid-packet aborts immediately. No beat is considered transferred in the reset cycle.
- FSM states: IDLE, LOCKED.
- IDLE:
  - Outputs: out_valid=0, req_ready=0.
  - If any req_valid is set: choose the first i with req_valid[i], scanning ptr, ptr+1, … modulo N_REQ.
  - Next edge: sel<=i, beat_cnt<=0, state<=LOCKED.
  - Grant latency is exactly 1 cycle from req_valid to out_valid.
  - If no req_valid is set: remain in IDLE.
- LOCKED (combinational path from inputs to outputs):
  - out_valid = req_valid[sel]
  - out_data = req_data[sel]
  - out_last = req_last[sel]
  - req_ready[sel] = out_ready; all other req_ready bits are 0
  - busy = 1
- Transfer: a beat transfers when out_valid && out_ready.
  - On each transfer: beat_cnt <= beat_cnt+1.
- Release:
  - On a transfer with out_last=1: state<=IDLE, ptr<=(sel+1) mod N_REQ, beat_cnt<=0.
  - On a transfer with out_last=0 where beat_cnt==MAX_BEATS-1: same release as above, plus preempt=1 on the next cycle for one cycle. The packet's remaining beats re-arbitrate later as a new grant.
- Bubble: one IDLE cycle always follows a release, so back-to-back packets achieve at most one beat per two cycles across a grant boundary. Within a packet, throughput is one beat per cycle.
- Granted requester drops req_valid mid-packet: the grant is held, out_valid=0, and beat_cnt is unchanged.
- Requests from non-granted requesters are ignored while LOCKED. Fairness: no requester waits more than N_REQ-1 grants.
- ptr wrap: from N_REQ-1 to 0. This also applies when N_REQ is not a power of two; sel never exceeds N_REQ-1.
- beat_cnt width: $clog2(MAX_BEATS+1). MAX_BEATS=1 forces release after every beat.
- out_ready is sampled only while LOCKED.
- The payload path is combinational through the mux; there is no data buffering.

Decomposition:
- Shared package mux_sched_pkg holds:
  - typedef enum logic {IDLE, LOCKED} sched_state_t
  - a function rr_pick(req, ptr) returning the index plus a found flag
- One sub-module: rr_pick_onehot, a combinational rotate-priority encoder taking N_REQ requests and ptr and returning the index and valid.
- The data mux is the existing parameterised N:1 mux driven by sel; it is not reimplemented in this block.

Test Plan:
1. Reset then idle: rst_n low with req_valid=4'b1111 → req_ready=0, out_valid=0, sel=0, busy=0. On release, the grant goes to req 0 after 1 cycle.
2. Single packet: req 2 sends 3 beats (data 0xA1, 0xA2, 0xA3; last on the third) with out_ready=1 → out_data matches in order, sel=2, busy is high for 3 cycles, then IDLE. The next scan starts at 3.
3. Round-robin fairness: all 4 requesters continuously send 1-beat packets → grant order 0, 1, 2, 3, 0, … with an IDLE bubble between each grant.
4. Backpressure: out_ready toggles 1, 0, 0, 1 during a 2-beat packet from req 1 → req_ready[1] mirrors out_ready. Exactly 2 transfers occur, and no beat is duplicated or dropped.
5. Preempt: MAX_BEATS=4, req 0 streams with last=0 and out_ready=1 → preempt pulses once after the 4th beat. Req 1, which is pending, is granted next, and req 0 is re-granted afterwards.
6. Async reset mid-packet: rst_n falls after beat 1 of a 3-beat packet → outputs return to reset values immediately. After release, arbitration restarts from ptr=0.
